// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//
// Conditions raw board push-buttons for the ALU top-level register bank.
// Each channel is synchronised to i_clk and then debounced. The block emits
// the debounced level and a one-cycle strobe on every accepted press, so a
// physical press loads an ALU operand or operation exactly once.
//
// Parameters:
//   NB_BUT           number of button channels
//   DEBOUNCE_CYCLES  consecutive disagreeing samples needed to accept a new
//                    level (must be >= 2)
//   NB_CNT           width of each per-channel debounce counter
//
// Ports:
//   i_clk        system clock, all state on the rising edge
//   i_rst        asynchronous active-low reset
//   i_btn_raw    raw button pins, asynchronous, active-high
//   o_btn_level  debounced level per channel (registered)
//   o_btn_pulse  registered one-cycle strobe on each debounced 0->1 change
//
// Build option:
//   BTN_PRIORITY_ONEHOT_EN  when defined, o_btn_pulse carries at most one set
//                           bit per cycle; the lowest index wins and losing
//                           strobes are dropped. o_btn_level is unaffected.
// -----------------------------------------------------------------------------
module btn_conditioner #(
  parameter int NB_BUT          = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NB_CNT          = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NB_BUT-1:0] i_btn_raw,
  output logic [NB_BUT-1:0] o_btn_level,
  output logic [NB_BUT-1:0] o_btn_pulse
);

  // Terminal count: the DEBOUNCE_CYCLES-th disagreeing sample commits.
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DEBOUNCE_CYCLES - 1);

  logic [NB_BUT-1:0] sync1;
  logic [NB_BUT-1:0] sync2;
  logic [NB_BUT-1:0] stable;
  logic [NB_BUT-1:0] stable_nxt;
  logic [NB_BUT-1:0] rise;
  logic [NB_BUT-1:0] pulse_nxt;
  logic [NB_CNT-1:0] cnt     [NB_BUT];
  logic [NB_CNT-1:0] cnt_nxt [NB_BUT];

  // Two-flop synchroniser; only sync2 is allowed to reach the debounce logic.
  // NOTE: registers are written with non-blocking assignments so every flop
  // samples the pre-edge value of its source, which is what makes sync2 lag
  // sync1 by a full cycle.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= i_btn_raw;
      sync2 <= sync1;
    end
  end

  // Debounce decision. Any agreeing sample clears the counter, so short
  // glitches never accumulate; the counter saturates at CNT_LAST by
  // committing and returning to zero instead of wrapping.
  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    stable_nxt = stable;
    rise       = '0;
    for (int i = 0; i < NB_BUT; i++) begin
      cnt_nxt[i] = '0;
      if (sync2[i] != stable[i]) begin
        if (cnt[i] == CNT_LAST) begin
          stable_nxt[i] = sync2[i];
          rise[i]       = sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + NB_CNT'(1);
        end
      end
    end
  end

`ifdef BTN_PRIORITY_ONEHOT_EN
  // Isolate the lowest set bit: btn[0] beats btn[1] beats btn[2], matching
  // the load priority of the ALU top. Losers are dropped, not queued.
  assign pulse_nxt = rise & (~rise + NB_BUT'(1));
`else
  assign pulse_nxt = rise;
`endif

  // Debounce state and registered strobe. A reset during a count or during a
  // strobe clears everything at once; release never produces a strobe since
  // stable restarts from 0 and a held button must pass the full debounce.
  // NOTE: the counter array is small per-channel state, not a memory, so it
  // is reset along with everything else rather than left uninitialised.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      stable      <= '0;
      o_btn_pulse <= '0;
      for (int i = 0; i < NB_BUT; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      stable      <= stable_nxt;
      o_btn_pulse <= pulse_nxt;
      for (int i = 0; i < NB_BUT; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  assign o_btn_level = stable;

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
//
// Self-checking bench for btn_conditioner with DEBOUNCE_CYCLES=4. Inputs are
// driven 1 ns after the rising edge and outputs are sampled at the same point,
// so each table row describes "raw applied before edge n, outputs after edge
// n". With this timing a level change on raw that holds from edge k commits at
// edge k+5. Multi-cycle corner cases (reset behaviour) are hand-written.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;

  localparam int NB_BUT = 3;
  localparam int DEB    = 4;

`ifdef BTN_PRIORITY_ONEHOT_EN
  localparam logic [2:0] SIM_PULSE = 3'b001;
`else
  localparam logic [2:0] SIM_PULSE = 3'b011;
`endif

  typedef struct {
    logic [2:0] raw;
    int         cycles;
    logic [2:0] lvl;
    logic [2:0] pls;
  } vec_t;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic [2:0] i_btn_raw = 3'b000;
  logic [2:0] o_btn_level;
  logic [2:0] o_btn_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[$];

  btn_conditioner #(
    .NB_BUT          (NB_BUT),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_btn_raw   (i_btn_raw),
    .o_btn_level (o_btn_level),
    .o_btn_pulse (o_btn_pulse)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [2:0] lvl, input logic [2:0] pls);
    check($sformatf("%s level", name), o_btn_level, lvl);
    check($sformatf("%s pulse", name), o_btn_pulse, pls);
  endtask

  // Holds reset for two edges with the given raw value, then releases it
  // 1 ns after an edge; the next rising edge is the first post-reset edge.
  task automatic do_reset(input logic [2:0] raw);
    i_rst     = 1'b0;
    i_btn_raw = raw;
    step();
    step();
    i_rst = 1'b1;
  endtask

  task automatic add_vec(input logic [2:0] raw, input int cycles,
                         input logic [2:0] lvl, input logic [2:0] pls);
    vec_t v;
    v.raw    = raw;
    v.cycles = cycles;
    v.lvl    = lvl;
    v.pls    = pls;
    vecs.push_back(v);
  endtask

  initial begin
    // Clean press on ch0, held well beyond the debounce window.
    add_vec(3'b001,  5, 3'b000, 3'b000);
    add_vec(3'b001,  1, 3'b001, 3'b001);
    add_vec(3'b001, 15, 3'b001, 3'b000);
    // Bounce on ch1: runs of 3 never reach the 4-sample threshold.
    add_vec(3'b011,  3, 3'b001, 3'b000);
    add_vec(3'b001,  1, 3'b001, 3'b000);
    add_vec(3'b011,  3, 3'b001, 3'b000);
    add_vec(3'b001,  6, 3'b001, 3'b000);
    // Release ch0: level falls, no strobe.
    add_vec(3'b000,  5, 3'b001, 3'b000);
    add_vec(3'b000,  1, 3'b000, 3'b000);
    add_vec(3'b000,  3, 3'b000, 3'b000);
    // Second press and release on ch0: a fresh strobe.
    add_vec(3'b001,  5, 3'b000, 3'b000);
    add_vec(3'b001,  1, 3'b001, 3'b001);
    add_vec(3'b001,  3, 3'b001, 3'b000);
    add_vec(3'b000,  5, 3'b001, 3'b000);
    add_vec(3'b000,  1, 3'b000, 3'b000);
    add_vec(3'b000,  3, 3'b000, 3'b000);
    // Simultaneous press on ch0 and ch1.
    add_vec(3'b011,  5, 3'b000, 3'b000);
    add_vec(3'b011,  1, 3'b011, SIM_PULSE);
    add_vec(3'b011,  4, 3'b011, 3'b000);
    add_vec(3'b000,  5, 3'b011, 3'b000);
    add_vec(3'b000,  1, 3'b000, 3'b000);
    add_vec(3'b000,  2, 3'b000, 3'b000);
    // Shortest accepted press on ch2: exactly 4 high samples.
    add_vec(3'b100,  4, 3'b000, 3'b000);
    add_vec(3'b000,  1, 3'b000, 3'b000);
    add_vec(3'b000,  1, 3'b100, 3'b100);
    add_vec(3'b000,  3, 3'b100, 3'b000);
    add_vec(3'b000,  1, 3'b000, 3'b000);
    add_vec(3'b000,  2, 3'b000, 3'b000);

    // ---- Reset with all buttons held ----
    i_rst     = 1'b0;
    i_btn_raw = 3'b111;
    #1;
    check_out("rst held t0", 3'b000, 3'b000);
    for (int i = 0; i < 2; i++) begin
      step();
      check_out($sformatf("rst held edge %0d", i), 3'b000, 3'b000);
    end
    i_rst = 1'b1;
    for (int e = 0; e < 5; e++) begin
      step();
      check_out($sformatf("post-rst edge %0d", e), 3'b000, 3'b000);
    end
    step();
    check_out("post-rst edge 5", 3'b111, 3'b111);
    for (int e = 6; e < 9; e++) begin
      step();
      check_out($sformatf("post-rst edge %0d", e), 3'b111, 3'b000);
    end

    // ---- Reset mid-count on ch2, then mid-pulse ----
    do_reset(3'b000);
    i_btn_raw = 3'b100;
    for (int e = 0; e < 4; e++) begin
      step();
      check_out($sformatf("midcnt edge %0d", e), 3'b000, 3'b000);
    end
    // Counter on ch2 now holds 2.
    i_rst = 1'b0;
    #1;
    check_out("midcnt async rst", 3'b000, 3'b000);
    for (int i = 0; i < 2; i++) begin
      step();
      check_out($sformatf("midcnt rst held %0d", i), 3'b000, 3'b000);
    end
    i_rst = 1'b1;
    for (int e = 0; e < 5; e++) begin
      step();
      check_out($sformatf("midcnt restart edge %0d", e), 3'b000, 3'b000);
    end
    step();
    check_out("midcnt restart edge 5", 3'b100, 3'b100);
    #1;
    i_rst = 1'b0;
    #1;
    check_out("midpulse async rst", 3'b000, 3'b000);
    step();
    check_out("midpulse rst held", 3'b000, 3'b000);

    // ---- Table-driven sequence from a clean reset ----
    do_reset(3'b000);
    for (int v = 0; v < vecs.size(); v++) begin
      for (int c = 0; c < vecs[v].cycles; c++) begin
        i_btn_raw = vecs[v].raw;
        step();
        check_out($sformatf("vec %0d cyc %0d", v, c), vecs[v].lvl, vecs[v].pls);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
